// File: rtl/exu_div_req_ctl.sv
// Divide request controller: holds one DIV/DIVU/REM/REMU op, issues it to the fixed-latency
// divider and returns the result to GPR writeback. Define EXU_DIV_LAT_CHECK_EN for latency monitoring.
module exu_div_req_ctl #(
    parameter int EXP_LAT = 34,
    parameter int LAT_W   = 6
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_sign,
    input  logic             req_rem,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_rs2,
    input  logic [4:0]       req_rd,
    input  logic             flush_lower,
    output logic             div_valid,
    output logic             div_sign,
    output logic             div_rem,
    output logic [31:0]      div_dividend,
    output logic [31:0]      div_divisor,
    input  logic             div_stall,
    input  logic             div_finish,
    input  logic [31:0]      div_out,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [4:0]       wb_rd,
    output logic [31:0]      wb_data,
    output logic             busy,
    output logic [LAT_W-1:0] lat_last,
    output logic             lat_err,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        WB    = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic [31:0] result_q;
    logic [4:0]  rd_q;
    logic        sign_q;
    logic        rem_q;
    logic        req_acc;
    logic        fin_take;

    // Handshakes: a request transfers on req_valid & req_ready & !flush_lower; a writeback
    // transfers on wb_valid & wb_ready & !flush_lower (flush wins); div_valid is a one-cycle
    // push with no back-pressure.
    assign req_acc  = (state == IDLE) & req_valid & ~flush_lower;
    assign fin_take = (state == WAIT) & div_finish & ~flush_lower;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        div_valid = 1'b0;
        wb_valid  = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_acc) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                div_valid = 1'b1;
                state_nxt = flush_lower ? DRAIN : WAIT;
            end
            WAIT: begin
                if (flush_lower) begin
                    state_nxt = div_stall ? DRAIN : IDLE;
                end else if (div_finish) begin
                    state_nxt = WB;
                end
            end
            WB: begin
                wb_valid = 1'b1;
                if (flush_lower || wb_ready) begin
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                // The divider is still working on the killed op; wait until it goes quiet.
                if (!div_stall && !div_finish) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rs1_q  <= '0;
            rs2_q  <= '0;
            rd_q   <= '0;
            sign_q <= 1'b0;
            rem_q  <= 1'b0;
        end else if (req_acc) begin
            rs1_q  <= req_rs1;
            rs2_q  <= req_rs2;
            rd_q   <= req_rd;
            sign_q <= req_sign;
            rem_q  <= req_rem;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            result_q <= '0;
        end else if (fin_take) begin
            result_q <= div_out;
        end
    end

    assign div_sign     = sign_q;
    assign div_rem      = rem_q;
    assign div_dividend = rs1_q;
    assign div_divisor  = rs2_q;
    assign wb_rd        = rd_q;
    assign wb_data      = result_q;
    assign dbg_state    = state;

`ifdef EXU_DIV_LAT_CHECK_EN
    localparam logic [LAT_W-1:0] LAT_MAX   = {LAT_W{1'b1}};
    localparam logic [LAT_W-1:0] EXP_LAT_V = LAT_W'(EXP_LAT);

    logic [LAT_W-1:0] lat_cnt;
    logic [LAT_W-1:0] lat_inc;
    logic [LAT_W-1:0] lat_last_q;
    logic             lat_err_q;

    // lat_cnt holds completed WAIT cycles, so lat_inc on the finish cycle equals the
    // distance from the div_valid cycle to the finish cycle.
    assign lat_inc = (lat_cnt == LAT_MAX) ? LAT_MAX : lat_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            lat_cnt    <= '0;
            lat_last_q <= '0;
            lat_err_q  <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                lat_cnt <= '0;
            end else if (state == WAIT) begin
                lat_cnt <= lat_inc;
            end
            if (fin_take) begin
                lat_last_q <= lat_inc;
                if (lat_inc != EXP_LAT_V) begin
                    lat_err_q <= 1'b1;
                end
            end
        end
    end

    assign lat_last = lat_last_q;
    assign lat_err  = lat_err_q;
`else
    assign lat_last = '0;
    assign lat_err  = 1'b0;
`endif

endmodule
